// File: rtl/ir_pkg.sv
// ir_pkg: clock, carrier and frame timing constants plus the FSM state enum shared by ir_decoder and ir_encoder.
// Rev 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps
package ir_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 25_000_000;
  localparam int unsigned CARRIER_HZ   = 36_000;
  localparam int unsigned ENV_HOLD_DEF = 512;

  // Nominal encoder timing in microseconds.
  localparam int unsigned START_MARK_US  = 5000;
  localparam int unsigned START_SPACE_US = 5000;
  localparam int unsigned BIT_MARK_US    = 420;
  localparam int unsigned ZERO_SPACE_US  = 420;
  localparam int unsigned ONE_SPACE_US   = 1240;

  // Classification windows in microseconds (4000 us = 100000 cycles at 25 MHz).
  localparam int unsigned START_MIN_US = 4000;
  localparam int unsigned START_MAX_US = 6000;
  localparam int unsigned MARK_MIN_US  = 280;
  localparam int unsigned MARK_MAX_US  = 560;
  localparam int unsigned ZERO_MIN_US  = 280;
  localparam int unsigned ZERO_MAX_US  = 600;
  localparam int unsigned ONE_MIN_US   = 1040;
  localparam int unsigned ONE_MAX_US   = 1440;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    START_MARK  = 3'd1,
    START_SPACE = 3'd2,
    BIT_MARK    = 3'd3,
    BIT_SPACE   = 3'd4
  } ir_state_t;

  function automatic int unsigned cycles_of(input int unsigned freq_hz, input int unsigned us);
    return (freq_hz / 1000) * us / 1000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ir_envelope.sv
// ir_envelope: optional 2-flop input synchronizer (IR_DEC_SYNC_EN) and carrier hold counter producing env.
// Rev 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps
module ir_envelope
  import ir_pkg::*;
#(
  parameter int ENV_HOLD = ENV_HOLD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ir_in,
  output logic env
);

  localparam int HOLD_W = $clog2(ENV_HOLD + 1);

  logic              ir_s;
  logic [HOLD_W-1:0] hold;

`ifdef IR_DEC_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], ir_in};
  end

  assign ir_s = sync[1];
`else
  assign ir_s = ir_in;
`endif

  // Each carrier pulse reloads the hold, bridging the carrier's low half-periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hold <= '0;
    else if (ir_s)           hold <= HOLD_W'(ENV_HOLD);
    else if (hold != '0)     hold <= hold - HOLD_W'(1);
  end

  assign env = (hold != '0);

endmodule
`default_nettype wire

// File: rtl/ir_decoder.sv
// ir_decoder: measures IR envelope mark/space durations and assembles 31-bit frames into cmd_out with a valid/ready handshake.
// Rev 1.0 - optional input synchronizer via IR_DEC_SYNC_EN
`default_nettype none
`timescale 1ns/1ps
module ir_decoder
  import ir_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_HZ,
  parameter int ENV_HOLD = ENV_HOLD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_in,
  output logic [31:0] cmd_out,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        frame_err,
  output logic        overrun
);

  localparam logic [17:0] START_MIN = 18'(cycles_of(CLK_FREQ, START_MIN_US));
  localparam logic [17:0] START_MAX = 18'(cycles_of(CLK_FREQ, START_MAX_US));
  localparam logic [17:0] MARK_MIN  = 18'(cycles_of(CLK_FREQ, MARK_MIN_US));
  localparam logic [17:0] MARK_MAX  = 18'(cycles_of(CLK_FREQ, MARK_MAX_US));
  localparam logic [17:0] ZERO_MIN  = 18'(cycles_of(CLK_FREQ, ZERO_MIN_US));
  localparam logic [17:0] ZERO_MAX  = 18'(cycles_of(CLK_FREQ, ZERO_MAX_US));
  localparam logic [17:0] ONE_MIN   = 18'(cycles_of(CLK_FREQ, ONE_MIN_US));
  localparam logic [17:0] ONE_MAX   = 18'(cycles_of(CLK_FREQ, ONE_MAX_US));

  logic        env, env_d, env_rise, env_fall;
  ir_state_t   state, next_state;
  logic [17:0] dur;
  logic [4:0]  bit_cnt;
  logic [30:0] sr;
  logic        err, done, shift_en, bit_val, frame_start;

  ir_envelope #(.ENV_HOLD(ENV_HOLD)) u_env (
    .clk   (clk),
    .rst_n (rst_n),
    .ir_in (ir_in),
    .env   (env)
  );

  assign env_rise    = env & ~env_d;
  assign env_fall    = ~env & env_d;
  assign frame_start = (state == START_SPACE) && (next_state == BIT_MARK);

  // Re-arming needs a rising edge, so an error taken while env is high waits for env low.
  always_comb begin
    next_state = state;
    err        = 1'b0;
    done       = 1'b0;
    shift_en   = 1'b0;
    bit_val    = 1'b0;
    case (state)
      IDLE: if (env_rise) next_state = START_MARK;
      START_MARK: begin
        if (env_fall) begin
          if (dur >= START_MIN && dur <= START_MAX) next_state = START_SPACE;
          else                                      err = 1'b1;
        end else if (dur > START_MAX) err = 1'b1;
      end
      START_SPACE: begin
        if (env_rise) begin
          if (dur >= START_MIN && dur <= START_MAX) next_state = BIT_MARK;
          else                                      err = 1'b1;
        end else if (dur > START_MAX) err = 1'b1;
      end
      BIT_MARK: begin
        if (env_fall) begin
          if (dur >= MARK_MIN && dur <= MARK_MAX) begin
            if (bit_cnt == 5'd31) done = 1'b1;
            else                  next_state = BIT_SPACE;
          end else err = 1'b1;
        end else if (dur > ONE_MAX) err = 1'b1;
      end
      BIT_SPACE: begin
        if (env_rise) begin
          if (dur >= ZERO_MIN && dur <= ZERO_MAX) begin
            shift_en   = 1'b1;
            next_state = BIT_MARK;
          end else if (dur >= ONE_MIN && dur <= ONE_MAX) begin
            shift_en   = 1'b1;
            bit_val    = 1'b1;
            next_state = BIT_MARK;
          end else err = 1'b1;
        end else if (dur > ONE_MAX) err = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    if (err || done) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      env_d   <= 1'b0;
      dur     <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state <= next_state;
      env_d <= env;
      if (next_state != state || env_rise || env_fall) dur <= '0;
      else if (dur != '1)                              dur <= dur + 18'd1;
      if (frame_start || err) begin
        bit_cnt <= '0;
        sr      <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 5'd1;
        sr      <= {bit_val, sr[30:1]};
      end
    end
  end

  // A completion that coincides with a handshake replaces the consumed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out   <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= err;
      overrun   <= done && cmd_valid && !cmd_ready;
      if (done && (!cmd_valid || cmd_ready)) begin
        cmd_out   <= {1'b0, sr};
        cmd_valid <= 1'b1;
      end else if (cmd_valid && cmd_ready) begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ir_decoder.sv
// tb_ir_decoder: directed frames with a scoreboard queue; timing scaled by running the decoder at CLK_FREQ=100 kHz.
// Rev 1.0 - initial release
`default_nettype none
`timescale 1ns/1ps
module tb_ir_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_in;
  logic [31:0] cmd_out;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        frame_err;
  logic        overrun;

  int vectors     = 0;
  int miscompares = 0;
  int err_seen    = 0;
  int err_exp     = 0;
  int ovr_seen    = 0;
  int ovr_exp     = 0;
  logic [31:0] exp_q[$];

  // Windows at 100 kHz: start 400..600, mark 28..56, zero 28..60, one 104..144.
  ir_decoder #(.CLK_FREQ(100_000), .ENV_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ir_in     (ir_in),
    .cmd_out   (cmd_out),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_mark(input int n);
    for (int i = 0; i < n; i++) begin
      ir_in = ((i % 4) < 2);
      tick();
    end
    ir_in = 1'b0;
  endtask

  task automatic send_space(input int n);
    ir_in = 1'b0;
    repeat (n) tick();
  endtask

  // bad_bit: that bit's space is 80 cycles (neither window); stop_bit: abort mid-mark of that bit.
  task automatic send_frame(input logic [31:0] cmd, input int bad_bit, input int stop_bit);
    send_mark(500);
    send_space(500);
    for (int b = 0; b < 32; b++) begin
      if (b == stop_bit) begin
        send_mark(20);
        return;
      end
      send_mark(40);
      if (b < 31) begin
        if (b == bad_bit) begin
          send_space(80);
          send_mark(40);
          send_space(300);
          return;
        end
        send_space(cmd[b] ? 120 : 40);
      end
    end
    send_space(300);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: samples on the falling edge, pops one expected frame per handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) err_seen++;
      if (overrun)   ovr_seen++;
      if (cmd_valid && cmd_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_frame: got %h, required no frame", cmd_out);
        end else begin
          check("frame_data", cmd_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    ir_in     = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) tick();
    check("rst_cmd_out", cmd_out, 32'h0);
    check("rst_cmd_valid", {31'b0, cmd_valid}, 32'h0);
    check("rst_frame_err", {31'b0, frame_err}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    rst_n = 1'b1;
    send_space(50);

    exp_q.push_back(32'h1234_5678);
    send_frame(32'h1234_5678, -1, -1);
    wait_drain();
    check("good_frame_no_err", 32'(err_seen), 32'(err_exp));

    exp_q.push_back(32'h7FFF_FFFF);
    send_frame(32'hFFFF_FFFF, -1, -1);
    wait_drain();

    // Start mark of 240 cycles is below the 400-cycle minimum.
    send_mark(240);
    send_space(700);
    err_exp++;
    check("short_start_err", 32'(err_seen), 32'(err_exp));
    check("short_start_valid", {31'b0, cmd_valid}, 32'h0);
    exp_q.push_back(32'h0000_00A5);
    send_frame(32'h0000_00A5, -1, -1);
    wait_drain();

    cmd_ready = 1'b0;
    exp_q.push_back(32'h0000_0011);
    send_frame(32'h0000_0011, -1, -1);
    send_frame(32'h0000_0022, -1, -1);
    ovr_exp++;
    check("overrun_hold_data", cmd_out, 32'h0000_0011);
    check("overrun_hold_valid", {31'b0, cmd_valid}, 32'h1);
    check("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    cmd_ready = 1'b1;
    tick();
    tick();
    check("ready_clears_valid", {31'b0, cmd_valid}, 32'h0);
    wait_drain();

    cmd_ready = 1'b0;
    send_frame(32'h0000_005A, -1, -1);
    check("held_before_reset", cmd_out, 32'h0000_005A);
    send_frame(32'hC3C3_0F0F, -1, 10);
    rst_n = 1'b0;
    #1;
    check("midframe_rst_cmd_out", cmd_out, 32'h0);
    check("midframe_rst_valid", {31'b0, cmd_valid}, 32'h0);
    check("midframe_rst_err", {31'b0, frame_err}, 32'h0);
    exp_q.delete();
    repeat (5) tick();
    cmd_ready = 1'b1;
    rst_n     = 1'b1;
    send_space(50);
    check("midframe_rst_no_err", 32'(err_seen), 32'(err_exp));
    exp_q.push_back(32'h43C3_0F0F);
    send_frame(32'hC3C3_0F0F, -1, -1);
    wait_drain();

    send_frame(32'h0000_00FF, 5, -1);
    err_exp++;
    check("bad_space_err", 32'(err_seen), 32'(err_exp));
    check("bad_space_valid", {31'b0, cmd_valid}, 32'h0);
    check("final_overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    check("final_err_count", 32'(err_seen), 32'(err_exp));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ir_decoder.md
IR_DECODER -- requirements
Module: ir_decoder

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 25_000_000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter ENV_HOLD, default 512, meaning the envelope hold time in clk cycles.
REQ-003 SHALL have port clk  input  1  system clock, 25 MHz.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port ir_in  input  1  raw 36 kHz-modulated IR line (ir_encoder ir_output format).
REQ-006 SHALL have port cmd_out  output  32  decoded command, LSB first on line.
REQ-007 SHALL have port cmd_valid  output  1  cmd_out holds an unconsumed frame.
REQ-008 SHALL have port cmd_ready  input  1  consumer accepts cmd_out.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a malformed frame.
REQ-010 SHALL have port overrun  output  1  one-cycle pulse when a frame is dropped because cmd_valid is still high.

Function
REQ-011 Envelope: a hold counter SHALL load ENV_HOLD each cycle ir_in=1 and decrement to 0 otherwise; env = (counter != 0).
REQ-012 A duration counter SHALL be 18 bits, clear on every state change and every env edge, increment per cycle, and saturate at all-ones.
REQ-013 FSM states SHALL be IDLE, START_MARK, START_SPACE, BIT_MARK, BIT_SPACE.
REQ-014 IDLE->START_MARK SHALL occur on env rising.
REQ-015 START_MARK: on env fall with count in 100000..150000 ->START_SPACE; else error.
REQ-016 START_SPACE: on env rise with count in 100000..150000 ->BIT_MARK with bit_cnt=0; else error.
REQ-017 BIT_MARK: on env fall with count in 7000..14000 ->BIT_SPACE if bit_cnt<31, frame complete if bit_cnt==31; else error.
REQ-018 BIT_SPACE: on env rise, count 7000..15000 SHALL give bit 0 and count 26000..36000 SHALL give bit 1; SHALL shift the bit in, increment bit_cnt, and go ->BIT_MARK; other counts error.
REQ-019 Any state other than IDLE SHALL error when count exceeds 150000 (start states) or 36000 (bit states) without an env edge.
REQ-020 Error SHALL pulse frame_err for one cycle, discard partial data, and return to IDLE; IDLE SHALL then wait for env low before re-arming.
REQ-021 The shift register SHALL be 31 bits, with new bits entering at bit 30 and shifting right; bit 31 is not carried on the line (its space merges into the gap) and SHALL be reported as 0.
REQ-022 Frame complete SHALL, if cmd_valid==0, load cmd_out={1'b0,sr} and set cmd_valid on the next cycle; if cmd_valid==1, keep the old data and pulse overrun; either way ->IDLE.
REQ-023 cmd_valid SHALL clear the cycle after cmd_valid&&cmd_ready; cmd_out SHALL be stable while cmd_valid is high.
REQ-024 If frame complete coincides with a handshake, the new frame SHALL be loaded, cmd_valid SHALL stay high, and there SHALL be no overrun.

Reset
REQ-025 rst_n low SHALL asynchronously force: cmd_out=0, cmd_valid=0, frame_err=0, overrun=0, state IDLE, all counters 0, env=0.
REQ-026 Reset mid-frame SHALL discard the frame silently (no frame_err).

Configuration
REQ-027 With IR_DEC_SYNC_EN defined, ir_in SHALL pass through a 2-flop synchronizer (reset 0) before envelope detection, adding 2 cycles latency; without it, ir_in SHALL feed the envelope directly.

Structure
REQ-028 Package ir_pkg SHALL hold CLK_FREQ, carrier and data timing constants, classification window bounds, and the FSM state enum shared with ir_encoder.
REQ-029 Sub-module ir_envelope SHALL contain the synchronizer option and the hold counter, and output env.

Verification
REQ-030 Encoder-format frame cmd=32'h1234_5678 -> cmd_out=32'h1234_5678, cmd_valid=1, no frame_err.
REQ-031 Frame cmd=32'hFFFF_FFFF -> cmd_out=32'h7FFF_FFFF.
REQ-032 Start mark of 60000 cycles -> frame_err pulse, cmd_valid stays 0, next good frame 32'h0000_00A5 decodes correctly.
REQ-033 Two frames 32'h11 and 32'h22 with cmd_ready=0 -> cmd_out=32'h11, one overrun pulse; cmd_ready=1 then clears cmd_valid.
REQ-034 rst_n low during bit 10 -> all outputs 0 immediately, no frame_err; next frame decodes.
REQ-035 Bit space of 20000 cycles -> frame_err, return to IDLE.
